alu_result_flags_stage: RTL and testbench

Execute-stage output buffer for the scalar ALU path: it takes the 24-bit result and the NZCV flags from the scalar adder/ALU, evaluates the instruction's 4-bit condition code against the architectural flags register, and commits NZCV when the instruction requests it. The committed result is held in a 2-entry skid buffer with valid/ready handshakes on both sides, so a stalled writeback stage never drops an ALU result. The block sits between the scalar ALU and the writeback stage.

---
 rtl/alu_result_flags_stage.sv | 144 ++++++++++++++
 tb/tb_alu_result_flags_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_flags_stage.sv
// Execute-stage output buffer: evaluates the condition code against the architectural
// NZCV register, commits flags, and holds results in a 2-entry skid buffer.
module alu_result_flags_stage #(
    parameter int N  = 24,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_result,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    input  logic          in_set_flags,
    input  logic [3:0]    in_cond,
    input  logic          in_n,
    input  logic          in_z,
    input  logic          in_c,
    input  logic          in_v,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          out_cond_pass,
    output logic [3:0]    flags_q
);

    localparam int EW = N + RW + 2;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e         state_q, state_d;
    logic [EW-1:0]  outEntry_q, outEntry_d;
    logic [EW-1:0]  skidEntry_q, skidEntry_d;
    logic [3:0]     flags_d;
    logic [EW-1:0]  inEntry;
    logic           condPass;
    logic           accept;
    logic           loadOutIn, loadOutSkid, loadSkid;
    logic           flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = flags_q;

    // Condition evaluation always uses the committed flags, so a flag write at one edge
    // is already visible to the entry accepted at the next edge.
    always_comb begin
        condPass = 1'b1;
        case (in_cond)
            4'd0:    condPass = flagZ;
            4'd1:    condPass = !flagZ;
            4'd2:    condPass = flagC;
            4'd3:    condPass = !flagC;
            4'd4:    condPass = flagN;
            4'd5:    condPass = !flagN;
            4'd6:    condPass = flagV;
            4'd7:    condPass = !flagV;
            4'd8:    condPass = flagC && !flagZ;
            4'd9:    condPass = !flagC || flagZ;
            4'd10:   condPass = (flagN == flagV);
            4'd11:   condPass = (flagN != flagV);
            4'd12:   condPass = !flagZ && (flagN == flagV);
            4'd13:   condPass = flagZ || (flagN != flagV);
            default: condPass = 1'b1;
        endcase
    end

    assign in_ready = (state_q != FULL);
    assign accept   = in_valid && in_ready && !flush;
    assign inEntry  = {in_result, in_rd, in_we && condPass, condPass};

    // Buffer control; flush overrides everything and drops both entries.
    always_comb begin
        state_d     = state_q;
        loadOutIn   = 1'b0;
        loadOutSkid = 1'b0;
        loadSkid    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        loadOutIn = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        loadOutIn = 1'b1;
                    end else if (accept) begin
                        state_d  = FULL;
                        loadSkid = 1'b1;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d     = ONE;
                        loadOutSkid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        outEntry_d  = outEntry_q;
        skidEntry_d = skidEntry_q;
        flags_d     = flags_q;
        if (loadOutIn) begin
            outEntry_d = inEntry;
        end else if (loadOutSkid) begin
            outEntry_d = skidEntry_q;
        end
        if (loadSkid) begin
            skidEntry_d = inEntry;
        end
        if (accept && in_set_flags && condPass) begin
            flags_d = {in_n, in_z, in_c, in_v};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            outEntry_q  <= '0;
            skidEntry_q <= '0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            outEntry_q  <= outEntry_d;
            skidEntry_q <= skidEntry_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign {out_result, out_rd, out_we, out_cond_pass} = outEntry_q;

endmodule

// File: tb/tb_alu_result_flags_stage.sv
// Scoreboard bench for alu_result_flags_stage: directed vectors push hand-computed
// expectations, a monitor pops and compares on every output transfer.
module tb_alu_result_flags_stage;

    typedef struct {
        logic [23:0] res;
        logic [3:0]  rd;
        logic        we;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_result;
    logic [3:0]  in_rd;
    logic        in_we;
    logic        in_set_flags;
    logic [3:0]  in_cond;
    logic        in_n, in_z, in_c, in_v;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic        out_cond_pass;
    logic [3:0]  flags_q;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    alu_result_flags_stage #(.N(24), .RW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_rd(in_rd), .in_we(in_we),
        .in_set_flags(in_set_flags), .in_cond(in_cond),
        .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
        .out_cond_pass(out_cond_pass), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    // Single comparison point: every check counts here and reports here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one entry and waits (bounded) for it to be accepted, then queues its
    // hand-computed expectation. Returns just after the accepting edge.
    task automatic applyStimulus(input logic [23:0] res, input logic [3:0] rd, input logic we,
                                 input logic setf, input logic [3:0] cond, input logic [3:0] nzcv,
                                 input logic expPass);
        exp_t e;
        logic rdy;
        bit   done;
        in_valid     = 1'b1;
        in_result    = res;
        in_rd        = rd;
        in_we        = we;
        in_set_flags = setf;
        in_cond      = cond;
        {in_n, in_z, in_c, in_v} = nzcv;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                e.res  = res;
                e.rd   = rd;
                e.we   = we & expPass;
                e.pass = expPass;
                expQ.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: entry %0h never accepted", res);
        end
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares the head of the scoreboard on each output handshake.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got result %0h with empty scoreboard", out_result);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("out_result", 32'(out_result), 32'(e.res));
                checkOutput("out_rd", 32'(out_rd), 32'(e.rd));
                checkOutput("out_we", 32'(out_we), 32'(e.we));
                checkOutput("out_cond_pass", 32'(out_cond_pass), 32'(e.pass));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_rd = '0; in_we = 1'b0; in_set_flags = 1'b0; in_cond = '0;
        {in_n, in_z, in_c, in_v} = 4'b0000;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_flags", 32'(flags_q), 32'd0);
        checkOutput("reset_out_result", 32'(out_result), 32'd0);
        checkOutput("reset_out_we", 32'(out_we), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic accept
        out_ready = 1'b1;
        applyStimulus(24'h000005, 4'd3, 1'b1, 1'b0, 4'd14, 4'b0000, 1'b1);
        checkOutput("basic_out_valid", 32'(out_valid), 32'd1);
        checkOutput("basic_out_result", 32'(out_result), 32'h5);
        checkOutput("basic_flags", 32'(flags_q), 32'd0);

        // Flag commit and dependent conditions back to back
        applyStimulus(24'h000010, 4'd1, 1'b1, 1'b1, 4'd14, 4'b0100, 1'b1);
        checkOutput("flags_after_set", 32'(flags_q), 32'h4);
        applyStimulus(24'h000011, 4'd2, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b1);
        applyStimulus(24'h000012, 4'd3, 1'b1, 1'b0, 4'd1, 4'b0000, 1'b0);
        applyStimulus(24'h000013, 4'd4, 1'b1, 1'b1, 4'd1, 4'b1111, 1'b0);
        checkOutput("flags_condfail_hold", 32'(flags_q), 32'h4);

        // Signed and unsigned compares
        applyStimulus(24'h000020, 4'd5, 1'b0, 1'b1, 4'd14, 4'b1000, 1'b1);
        checkOutput("flags_n1v0", 32'(flags_q), 32'h8);
        applyStimulus(24'h000021, 4'd6, 1'b1, 1'b0, 4'd10, 4'b0000, 1'b0);
        applyStimulus(24'h000022, 4'd7, 1'b1, 1'b0, 4'd11, 4'b0000, 1'b1);
        applyStimulus(24'h000023, 4'd8, 1'b0, 1'b1, 4'd14, 4'b1001, 1'b1);
        checkOutput("flags_n1v1", 32'(flags_q), 32'h9);
        applyStimulus(24'h000024, 4'd9, 1'b1, 1'b0, 4'd12, 4'b0000, 1'b1);
        applyStimulus(24'h000025, 4'd10, 1'b1, 1'b0, 4'd13, 4'b0000, 1'b0);
        applyStimulus(24'h000026, 4'd11, 1'b1, 1'b0, 4'd8, 4'b0000, 1'b0);
        applyStimulus(24'h000027, 4'd12, 1'b1, 1'b0, 4'd9, 4'b0000, 1'b1);
        idleCycles(3);
        checkOutput("drained_1", 32'(expQ.size()), 32'd0);

        // Backpressure: A, B fill the buffer, C waits
        out_ready = 1'b0;
        applyStimulus(24'h0000AA, 4'd1, 1'b1, 1'b0, 4'd14, 4'b0000, 1'b1);
        applyStimulus(24'h0000BB, 4'd2, 1'b1, 1'b0, 4'd14, 4'b0000, 1'b1);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        idleCycles(2);
        checkOutput("stall_stable_result", 32'(out_result), 32'hAA);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        applyStimulus(24'h0000CC, 4'd3, 1'b1, 1'b0, 4'd14, 4'b0000, 1'b1);
        idleCycles(3);
        checkOutput("drained_2", 32'(expQ.size()), 32'd0);

        // Flush from FULL with a live input that would set flags
        out_ready = 1'b0;
        applyStimulus(24'h0000D1, 4'd4, 1'b1, 1'b0, 4'd14, 4'b0000, 1'b1);
        applyStimulus(24'h0000D2, 4'd5, 1'b1, 1'b0, 4'd14, 4'b0000, 1'b1);
        in_valid = 1'b1; in_result = 24'h0000F1; in_set_flags = 1'b1; in_cond = 4'd14;
        {in_n, in_z, in_c, in_v} = 4'b0110;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        expQ.delete();
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_flags", 32'(flags_q), 32'h9);
        out_ready = 1'b1;
        idleCycles(3);

        // Asynchronous reset from FULL
        out_ready = 1'b0;
        applyStimulus(24'h0000E1, 4'd6, 1'b1, 1'b1, 4'd14, 4'b0010, 1'b1);
        applyStimulus(24'h0000E2, 4'd7, 1'b1, 1'b0, 4'd14, 4'b0000, 1'b1);
        checkOutput("pre_reset_flags", 32'(flags_q), 32'h2);
        checkOutput("pre_reset_full", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_flags", 32'(flags_q), 32'd0);
        checkOutput("async_in_ready", 32'(in_ready), 32'd1);
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        idleCycles(3);
        checkOutput("final_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
